// File: rtl/da_dct4_engine.sv
// rtl/da_dct4_engine.sv - 4-point DCT engine, bit-serial distributed arithmetic, 4 tables in parallel
// Macro DA_DCT_ROUND_EN: round coefficients to integers instead of 2^-10 fixed point.
module da_dct4_engine #(
   parameter int DATA_W = 8,
   localparam int OUT_W = DATA_W + 15
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic signed [DATA_W-1:0] x0,
   input  logic signed [DATA_W-1:0] x1,
   input  logic signed [DATA_W-1:0] x2,
   input  logic signed [DATA_W-1:0] x3,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic signed [OUT_W-1:0]  y0,
   output logic signed [OUT_W-1:0]  y1,
   output logic signed [OUT_W-1:0]  y2,
   output logic signed [OUT_W-1:0]  y3
);
   localparam int TAB_W = 15;
   localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(DATA_W - 1);
`ifdef DA_DCT_ROUND_EN
   localparam logic signed [OUT_W-1:0] RND_HALF = OUT_W'(512);
`endif

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t                   r_state;
   state_t                   w_state_nxt;
   logic [CNT_W-1:0]         r_cnt;
   logic [DATA_W-1:0]        r_x       [4];
   logic signed [OUT_W-1:0]  r_acc     [4];
   logic signed [OUT_W-1:0]  r_y       [4];
   logic [3:0]               w_addr;
   logic                     w_first;
   logic signed [TAB_W-1:0]  w_tab     [4];
   logic signed [OUT_W-1:0]  w_tab_ext [4];
   logic signed [OUT_W-1:0]  w_acc_nxt [4];
   logic signed [OUT_W-1:0]  w_res     [4];

   // Rows k0 and k2 use 724 per term once two or more samples contribute.
   function automatic logic signed [TAB_W-1:0] f_tab(input int k, input logic [3:0] a);
      int n_set;
      int ca;
      int sum;
      int c [4];
      n_set = 0;
      for (int n = 0; n < 4; n++) n_set += int'(a[n]);
      ca = (n_set >= 2) ? 724 : 723;
      case (k)
         0:       c = '{ca, ca, ca, ca};
         1:       c = '{946, 391, -391, -946};
         2:       c = '{ca, -ca, -ca, ca};
         default: c = '{391, -946, 946, -391};
      endcase
      sum = 0;
      for (int n = 0; n < 4; n++) begin
         if (a[3-n]) sum += c[n];
      end
      return TAB_W'(sum);
   endfunction

   always_comb begin
      w_first = (r_cnt == CNT_TOP);
      w_addr  = {r_x[0][r_cnt], r_x[1][r_cnt], r_x[2][r_cnt], r_x[3][r_cnt]};
      for (int k = 0; k < 4; k++) begin
         w_tab[k]     = f_tab(k, w_addr);
         w_tab_ext[k] = {{DATA_W{w_tab[k][TAB_W-1]}}, w_tab[k]};
         // The sign bit slice carries weight -2^(DATA_W-1).
         w_acc_nxt[k] = w_first ? -w_tab_ext[k] : (r_acc[k] <<< 1) + w_tab_ext[k];
`ifdef DA_DCT_ROUND_EN
         w_res[k]     = (w_acc_nxt[k] + RND_HALF) >>> 10;
`else
         w_res[k]     = w_acc_nxt[k];
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      case (r_state)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) w_state_nxt = S_RUN;
         end
         S_RUN: begin
            if (r_cnt == '0) w_state_nxt = S_DONE;
         end
         S_DONE: begin
            out_valid = 1'b1;
            if (out_ready) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
         for (int k = 0; k < 4; k++) begin
            r_x[k]   <= '0;
            r_acc[k] <= '0;
            r_y[k]   <= '0;
         end
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_x[0] <= x0;
                  r_x[1] <= x1;
                  r_x[2] <= x2;
                  r_x[3] <= x3;
                  r_cnt  <= CNT_TOP;
               end
            end
            S_RUN: begin
               for (int k = 0; k < 4; k++) r_acc[k] <= w_acc_nxt[k];
               if (r_cnt == '0) begin
                  for (int k = 0; k < 4; k++) r_y[k] <= w_res[k];
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign y0 = r_y[0];
   assign y1 = r_y[1];
   assign y2 = r_y[2];
   assign y3 = r_y[3];
endmodule

// File: tb/tb_da_dct4_engine.sv
// tb/tb_da_dct4_engine.sv - randomized scoreboard bench for da_dct4_engine
// Honors DA_DCT_ROUND_EN in its reference model.
module tb_da_dct4_engine;
   localparam int DW = 8;
   localparam int OW = DW + 15;

   logic                 clk       = 1'b0;
   logic                 rst       = 1'b1;
   logic                 in_valid  = 1'b0;
   logic                 out_ready = 1'b1;
   logic signed [DW-1:0] x0 = '0, x1 = '0, x2 = '0, x3 = '0;
   logic                 in_ready;
   logic                 out_valid;
   logic signed [OW-1:0] y0, y1, y2, y3;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int bp_mode = 0;
   bit prev_v = 1'b0;

   typedef struct {
      longint y [4];
      int     hs;
   } exp_t;
   exp_t sb [$];

   da_dct4_engine #(.DATA_W(DW)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .x0(x0), .x1(x1), .x2(x2), .x3(x3),
      .out_valid(out_valid), .out_ready(out_ready),
      .y0(y0), .y1(y1), .y2(y2), .y3(y3)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      #1;
      if (bp_mode == 0)      out_ready = 1'b1;
      else if (bp_mode == 1) out_ready = 1'($urandom_range(0, 1));
   end

   function automatic longint rnd(input longint v);
`ifdef DA_DCT_ROUND_EN
      return (v + 512) >>> 10;
`else
      return v;
`endif
   endfunction

   // Table entry: sum of row coefficients of the samples whose bit is set.
   function automatic longint tab(input int k, input logic [3:0] a);
      int rows [4][4];
      int av;
      longint s;
      av = ($countones(a) >= 2) ? 724 : 723;
      rows = '{'{av, av, av, av}, '{946, 391, -391, -946},
               '{av, -av, -av, av}, '{391, -946, 946, -391}};
      s = 0;
      for (int n = 0; n < 4; n++) if (a[3-n]) s += rows[k][n];
      return s;
   endfunction

   function automatic longint model(input int k, input logic signed [DW-1:0] xa [4]);
      longint acc;
      longint w;
      logic [3:0] a;
      acc = 0;
      for (int j = 0; j < DW; j++) begin
         a = {xa[0][j], xa[1][j], xa[2][j], xa[3][j]};
         w = longint'(1) << j;
         if (j == DW - 1) w = -w;
         acc += w * tab(k, a);
      end
      return rnd(acc);
   endfunction

   task automatic send(input logic signed [DW-1:0] a, b, c, d,
                       input longint e0, e1, e2, e3);
      exp_t e;
      int n;
      @(posedge clk); #1;
      x0 = a; x1 = b; x2 = c; x3 = d;
      in_valid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 300) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (!in_ready) begin
         bad++;
         $display("FAIL send_timeout in_ready=%0b required=1", in_ready);
         in_valid = 1'b0;
      end else begin
         e.y[0] = e0; e.y[1] = e1; e.y[2] = e2; e.y[3] = e3;
         e.hs = cyc;
         sb.push_back(e);
         @(posedge clk); #1;
         in_valid = 1'b0;
      end
   endtask

   task automatic send_lit(input logic signed [DW-1:0] a, b, c, d,
                           input longint l0, l1, l2, l3);
      send(a, b, c, d, rnd(l0), rnd(l1), rnd(l2), rnd(l3));
   endtask

   task automatic send_rand();
      logic signed [DW-1:0] xa [4];
      for (int n = 0; n < 4; n++) begin
         case ($urandom_range(0, 5))
            0:       xa[n] = -128;
            1:       xa[n] = 127;
            default: xa[n] = DW'($urandom);
         endcase
      end
      send(xa[0], xa[1], xa[2], xa[3], model(0, xa), model(1, xa), model(2, xa), model(3, xa));
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL drain_timeout pending=%0d required=0", sb.size());
      end
   endtask

   always @(negedge clk) begin
      if (rst) begin
         prev_v = 1'b0;
      end else begin
         if (out_valid) begin
            total++;
            if (sb.size() == 0) begin
               bad++;
               $display("FAIL unexpected_output y=%0d,%0d,%0d,%0d required=none", y0, y1, y2, y3);
            end else begin
               if (longint'(y0) != sb[0].y[0] || longint'(y1) != sb[0].y[1] ||
                   longint'(y2) != sb[0].y[2] || longint'(y3) != sb[0].y[3]) begin
                  bad++;
                  $display("FAIL y_value got=%0d,%0d,%0d,%0d required=%0d,%0d,%0d,%0d",
                           y0, y1, y2, y3, sb[0].y[0], sb[0].y[1], sb[0].y[2], sb[0].y[3]);
               end
               if (!prev_v) begin
                  total++;
                  if (cyc - sb[0].hs != DW + 1) begin
                     bad++;
                     $display("FAIL latency got=%0d required=%0d", cyc - sb[0].hs, DW + 1);
                  end
               end
               if (out_ready) void'(sb.pop_front());
            end
         end
         prev_v = out_valid;
      end
   end

   initial begin
      int n;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      total++;
      if (out_valid !== 1'b0 || y0 !== '0 || y1 !== '0 || y2 !== '0 || y3 !== '0) begin
         bad++;
         $display("FAIL reset_state out_valid=%0b y=%0d,%0d,%0d,%0d required=0", out_valid, y0, y1, y2, y3);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      total++;
      if (in_ready !== 1'b1) begin
         bad++;
         $display("FAIL ready_after_reset in_ready=%0b required=1", in_ready);
      end

      send_lit(1, 0, 0, 0, 723, 946, 723, 391);
      send_lit(1, 1, 1, 1, 2896, 0, 0, 0);
      send_lit(-1, 0, 0, 0, -723, -946, -723, -391);
      send_lit(-128, -128, -128, -128, -370688, 0, 0, 0);
      drain();

      // Backpressure: hold out_ready low in DONE and offer a block that must be ignored.
      bp_mode = 2;
      @(posedge clk); #1;
      out_ready = 1'b0;
      send_lit(0, 1, 0, 0, 723, 391, -723, -946);
      n = 0;
      @(negedge clk);
      while (!out_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (!out_valid) begin
         bad++;
         $display("FAIL stall_wait out_valid=%0b required=1", out_valid);
      end
      @(posedge clk); #1;
      in_valid = 1'b1;
      x0 = 7; x1 = -3; x2 = 12; x3 = 99;
      repeat (5) begin
         @(negedge clk);
         total++;
         if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            bad++;
            $display("FAIL stall_hold in_ready=%0b out_valid=%0b required=0,1", in_ready, out_valid);
         end
         @(posedge clk); #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      total++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || sb.size() != 0) begin
         bad++;
         $display("FAIL stall_release in_ready=%0b out_valid=%0b pending=%0d required=1,0,0",
                  in_ready, out_valid, sb.size());
      end
      bp_mode = 0;

      // Reset during the 4th RUN cycle discards the block.
      send_lit(0, 0, 1, 0, 723, -391, -723, 946);
      repeat (3) begin
         @(posedge clk); #1;
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      sb.delete();
      @(negedge clk);
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 ||
          y0 !== '0 || y1 !== '0 || y2 !== '0 || y3 !== '0) begin
         bad++;
         $display("FAIL mid_run_reset out_valid=%0b in_ready=%0b y=%0d,%0d,%0d,%0d required=0,1,0",
                  out_valid, in_ready, y0, y1, y2, y3);
      end
      send_lit(1, 0, 0, 0, 723, 946, 723, 391);
      drain();

      bp_mode = 1;
      repeat (40) send_rand();
      drain();
      bp_mode = 0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/da_dct4_engine.md
DA_DCT4_ENGINE -- requirements
Module: da_dct4_engine

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning two's-complement input sample width; legal range 2..16.
REQ-002 SHALL have localparam OUT_W = DATA_W+15, meaning output coefficient width in units of 2^-10.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic rises on posedge clk.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset, sampled on posedge clk.
REQ-005 SHALL have port in_valid, input, 1, meaning the input block is valid.
REQ-006 SHALL have port in_ready, output, 1, meaning the engine accepts a block.
REQ-007 SHALL have ports x0, x1, x2, x3, input, DATA_W each, meaning signed samples n=0..3.
REQ-008 SHALL have port out_valid, output, 1, meaning y0..y3 are valid.
REQ-009 SHALL have port out_ready, input, 1, meaning downstream accepts the result.
REQ-010 SHALL have ports y0, y1, y2, y3, output, OUT_W each, meaning signed 4-point DCT coefficients k=0..3.

Function
REQ-011 SHALL compute y_k = sum_n c_{k,n}*x_n by distributed arithmetic using one 15-bit signed table per k, with 4 tables evaluated in parallel.
REQ-012 SHALL form table address bit-slice A_j = {x0[j],x1[j],x2[j],x3[j]}, where x0 is the MSB of A.
REQ-013 SHALL use coefficient rows k0 = [A,A,A,A], k1 = [B,C,-C,-B], k2 = [A,-A,-A,A], k3 = [C,-B,B,-C], with A=723, B=946, C=391.
REQ-014 SHALL set each table entry to the sum of the row coefficients for the set bits of A, except that k0 and k2 entries with 2 or more set bits SHALL use 724 per A term (values 1448, 2172, 2896, -1448), and address 0 SHALL give 0.
REQ-015 SHALL process bits MSB-first in state RUN: at j=DATA_W-1 acc_k = -T_k(A_j); for each later j, acc_k = 2*acc_k + T_k(A_j); accumulators are OUT_W signed with no overflow possible.
REQ-016 SHALL implement the FSM IDLE -> RUN -> DONE -> IDLE.
REQ-017 SHALL set in_ready=1 only in IDLE; the in_valid&&in_ready cycle SHALL latch x0..x3 and enter RUN with bit counter = DATA_W-1.
REQ-018 SHALL stay in RUN exactly DATA_W cycles, decrementing the counter, then enter DONE.
REQ-019 SHALL, in DONE, assert out_valid with registered y0..y3 held stable until out_valid&&out_ready, then return to IDLE.
REQ-020 SHALL give a latency of DATA_W+1 cycles from the input handshake edge to out_valid high, and a minimum block period of DATA_W+2 cycles.
REQ-021 SHALL ignore in_valid outside IDLE (no latch, no state change).
REQ-022 SHALL leave y0..y3 unchanged outside DONE except on reset.

Reset
REQ-023 SHALL, on rst=1 at posedge clk, force IDLE, out_valid=0, y0..y3=0, accumulators=0 and counter=0, even mid-RUN or mid-DONE, discarding the block.
REQ-024 SHALL give in_ready=1 in the first cycle after rst deasserts.

Configuration
REQ-025 SHALL, with macro DA_DCT_ROUND_EN defined, output y_k = (acc_k + 512) >>> 10, sign-extended to OUT_W (round half up to integer).
REQ-026 SHALL, without DA_DCT_ROUND_EN, output y_k = acc_k at full precision in units of 2^-10.

Verification (DATA_W=8, no macro unless stated)
REQ-027 SHALL cover x={1,0,0,0} -> y={723,946,723,391}, out_valid 9 cycles after the handshake.
REQ-028 SHALL cover x={1,1,1,1} -> y={2896,0,0,0}, and x={-1,0,0,0} -> y={-723,-946,-723,-391}.
REQ-029 SHALL cover x={-128,-128,-128,-128} -> y0=-370688, y1=y2=y3=0.
REQ-030 SHALL cover out_ready held low for 5 cycles in DONE -> out_valid and y stable, in_ready=0, and a new in_valid ignored; IDLE follows the cycle out_ready=1.
REQ-031 SHALL cover rst asserted at the 4th RUN cycle -> next cycle out_valid=0, y=0, in_ready=1; a following block x={1,0,0,0} gives the REQ-027 result.
REQ-032 SHALL cover DA_DCT_ROUND_EN with x={1,0,0,0} -> y={1,1,1,0}.
